// File: rtl/skid_stream_fifo.sv
// Valid/ready stream FIFO: RAM with registered read feeding a show-ahead output register.
// Advisory wrReadyOutOut leaves FIFO_SKID words of headroom; writes are only dropped when truly full.
module skid_stream_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 256,
    parameter int FIFO_SKID   = 32,
    parameter int AE_THRESH   = 4,
    localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flushIn,
    input  logic [DATA_WIDTH-1:0]  wrDataIn,
    input  logic                   wrValidIn,
    output logic                   wrReadyOutOut,
    output logic [DATA_WIDTH-1:0]  rdDataOut,
    output logic                   rdValidOut,
    input  logic                   rdReadyIn,
    output logic [COUNT_WIDTH-1:0] levelOut,
    output logic                   almostEmptyOut,
    output logic                   overflowOut
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] READY_C = COUNT_WIDTH'(FIFO_DEPTH - FIFO_SKID);
    localparam logic [COUNT_WIDTH-1:0] AE_C    = COUNT_WIDTH'(AE_THRESH);

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]  ram_q;
    logic                   s1_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_valid_q;
    logic [COUNT_WIDTH-1:0] level_q, level_d;
    logic                   wr_ready_q, ae_q, ovf_q;

    logic pop, push, drop, full, out_take, s1_load, mem_nonempty, run;
    logic [COUNT_WIDTH-1:0] in_pipe;

    always_comb begin
        run          = !rst && !flushIn;
        full         = (level_q == DEPTH_C);
        pop          = out_valid_q && rdReadyIn;
        push         = wrValidIn && (!full || pop);
        drop         = wrValidIn && full && !pop;
        // Words still in RAM = level minus whatever sits in the two output stages.
        in_pipe      = COUNT_WIDTH'(s1_valid_q) + COUNT_WIDTH'(out_valid_q);
        mem_nonempty = (level_q > in_pipe);
        out_take     = !out_valid_q || pop;
        s1_load      = mem_nonempty && (!s1_valid_q || out_take);
        if (!run) begin
            level_d = '0;
        end else begin
            level_d = level_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (run && push) begin
            mem[wr_ptr_q] <= wrDataIn;
        end
        if (run && s1_load) begin
            ram_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            level_q     <= '0;
            wr_ready_q  <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
        end else if (flushIn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            level_q     <= '0;
            wr_ready_q  <= (level_d < READY_C);
            ae_q        <= (level_d <= AE_C);
            ovf_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (s1_load) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            s1_valid_q <= s1_load || (s1_valid_q && !out_take);
            if (out_take) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= ram_q;
                end
            end
            level_q    <= level_d;
            wr_ready_q <= (level_d < READY_C);
            ae_q       <= (level_d <= AE_C);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign wrReadyOutOut  = wr_ready_q;
    assign rdDataOut      = out_data_q;
    assign rdValidOut     = out_valid_q;
    assign levelOut       = level_q;
    assign almostEmptyOut = ae_q;
    assign overflowOut    = ovf_q;

endmodule

// File: tb/tb_skid_stream_fifo.sv
// Bench for skid_stream_fifo: directed scenarios plus randomized traffic against a queue model.
// The model says a word is visible once it is at the head and two edges old.
module tb_skid_stream_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int SKID  = 32;
    localparam int AE    = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst, flushIn, wrValidIn, rdReadyIn;
    logic [DW-1:0] wrDataIn;
    logic          wrReadyOutOut, rdValidOut, almostEmptyOut, overflowOut;
    logic [DW-1:0] rdDataOut;
    logic [CW-1:0] levelOut;

    skid_stream_fifo #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .FIFO_SKID (SKID),
        .AE_THRESH (AE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flushIn       (flushIn),
        .wrDataIn      (wrDataIn),
        .wrValidIn     (wrValidIn),
        .wrReadyOutOut (wrReadyOutOut),
        .rdDataOut     (rdDataOut),
        .rdValidOut    (rdValidOut),
        .rdReadyIn     (rdReadyIn),
        .levelOut      (levelOut),
        .almostEmptyOut(almostEmptyOut),
        .overflowOut   (overflowOut)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [DW-1:0] m_data [$];
    int            m_time [$];
    int            m_cyc   = 0;
    logic          m_valid = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_inrst = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic wv,
                        input logic [DW-1:0] wd, input logic rr);
        logic pop_m;
        rst = r; flushIn = fl; wrValidIn = wv; wrDataIn = wd; rdReadyIn = rr;
        @(posedge clk);
        m_cyc++;
        if (r || fl) begin
            m_data.delete();
            m_time.delete();
            m_ovf   = 1'b0;
            m_inrst = r;
        end else begin
            m_inrst = 1'b0;
            pop_m   = m_valid && rr;
            if (wv && (m_data.size() < DEPTH || pop_m)) begin
                m_data.push_back(wd);
                m_time.push_back(m_cyc);
            end else if (wv) begin
                m_ovf = 1'b1;
            end
            if (pop_m) begin
                void'(m_data.pop_front());
                void'(m_time.pop_front());
            end
        end
        m_valid = (m_data.size() > 0) && (m_cyc - m_time[0] >= 2);
        #1;
        check("level", 32'(levelOut), 32'(m_data.size()));
        check("rdValid", 32'(rdValidOut), 32'(m_valid));
        if (m_valid) check("rdData", rdDataOut, m_data[0]);
        if (r) check("rdData_rst", rdDataOut, 32'h0);
        check("wrReady", 32'(wrReadyOutOut),
              32'(!m_inrst && (m_data.size() < DEPTH - SKID)));
        check("almostEmpty", 32'(almostEmptyOut), 32'(m_data.size() <= AE));
        check("overflow", 32'(overflowOut), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, base + DW'(i), 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    int sweep_n [13] = '{1, 2, 3, 4, 5, 6, 100, 223, 224, 225, 255, 256, 257};

    initial begin
        rst = 1'b1; flushIn = 1'b0; wrValidIn = 1'b0; wrDataIn = '0; rdReadyIn = 1'b0;

        do_reset();
        idle(1);

        step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
        idle(2);
        drain(2);

        foreach (sweep_n[k]) begin
            fill(sweep_n[k], 32'h0);
            idle(2);
            drain(sweep_n[k] + 3);
            do_reset();
            idle(1);
        end

        fill(DEPTH, 32'h1000);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        drain(DEPTH + 2);

        fill(100, 32'h2000);
        step(1'b0, 1'b1, 1'b1, 32'h5555, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'hA5, 1'b0);
        idle(2);
        drain(2);

        for (int ph = 0; ph < 12; ph++) begin
            int unsigned wp = $urandom_range(10, 100);
            int unsigned rp = $urandom_range(0, 100);
            if (ph == 7) do_reset();
            for (int i = 0; i < 400; i++) begin
                step(1'b0, ($urandom_range(0, 299) == 0),
                     ($urandom_range(1, 100) <= wp), $urandom,
                     ($urandom_range(1, 100) <= rp));
            end
        end
        drain(DEPTH + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/skid_stream_fifo.md
Name: skid_stream_fifo

Overview:
- Parametrised successor to the team's fixed 32-bit valid/ready FIFO.
- Adds configurable data width, a fill-level output, an almost-empty flag, a synchronous flush, and a sticky overflow flag.
- Keeps the skid-based advisory wrReadyOut, so upstream pipelines up to FIFO_SKID deep can stop late without losing data.
- Sits between accelerator datapath stages and the RISC-V load/store streaming interface.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- FIFO_DEPTH, 256, storage in words; power of 2, at least 4.
- FIFO_SKID, 32, headroom kept after wrReadyOut deasserts; valid range 0 to FIFO_DEPTH-1.
- AE_THRESH, 4, almostEmptyOut asserts when level <= AE_THRESH.
- COUNT_WIDTH (localparam), $clog2(FIFO_DEPTH+1), width of levelOut.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flushIn  in  1  synchronous clear of contents and flags.
- wrDataIn  in  DATA_WIDTH  write data.
- wrValidIn  in  1  write request.
- wrReadyOutOut  out  1  advisory ready; high while level < FIFO_DEPTH-FIFO_SKID.
- rdDataOut  out  DATA_WIDTH  head-of-queue data; valid when rdValidOut=1.
- rdValidOut  out  1  head word present.
- rdReadyIn  in  1  consumer pop request.
- levelOut  out  COUNT_WIDTH  words held; includes words in the output pipeline.
- almostEmptyOut  out  1  high when levelOut <= AE_THRESH.
- overflowOut  out  1  sticky; a write was dropped.

Behaviour:
- Reset values (rst high): wrReadyOut=0, rdValidOut=0, rdDataOut=0, levelOut=0, overflowOut=0, almostEmptyOut=1. wrReadyOut goes to 1 on the first edge after rst deasserts.
- Priority order: rst > flushIn > normal operation.
- Reset mid-operation discards all contents. No partial state survives.
- Push condition: wrValidIn=1 at an edge, and either level < FIFO_DEPTH or a pop occurs at the same edge.
- wrReadyOut does NOT gate writes. Writes are accepted while in skid space.
- Dropped write: wrValidIn=1 with level==FIFO_DEPTH and no pop. The word is discarded, overflowOut sets and holds until rst or flushIn, and level is unchanged.
- Pop condition: rdValidOut=1 and rdReadyIn=1 at an edge. rdReadyIn while rdValidOut=0 is ignored; there is no underflow.
- Storage: RAM with registered read plus a show-ahead output register. No combinational path from wrDataIn to rdDataOut.
- Write-to-read latency, empty FIFO: a word pushed at edge k gives rdValidOut=0 after edge k+1 and rdValidOut=1 after edge k+2, with that word on rdDataOut.
- Throughput: with rdReadyIn held high and data available, one word is popped per cycle. No bubbles once the pipeline has primed.
- rdDataOut is stable while rdValidOut=1 and no pop occurs.
- levelOut, registered, updates at the edge of the event:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - flush: 0
- wrReadyOut and almostEmptyOut are registered, derived from the next-state level. They are consistent with levelOut in the same cycle.
- Wrap-around: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Ordering is strictly FIFO across wrap.
- Full with simultaneous push and pop: both are accepted, level stays FIFO_DEPTH, no overflow.
- flushIn at an edge:
  - empties storage and the output register; rdValidOut=0 next cycle
  - levelOut=0, overflowOut=0, wrReadyOut=1
  - a write or pop in the same cycle is ignored
- FIFO_SKID=0: wrReadyOut=0 only when full.

Test Plan:
- Reset release: hold rst 10 cycles, then deassert -> after 1 edge: wrReadyOut=1, rdValidOut=0, levelOut=0, almostEmptyOut=1, overflowOut=0.
- Single word: push 0x00000000 at edge k -> rdValidOut=0 after k+1, rdValidOut=1 with rdDataOut=0x00000000 after k+2. Pop -> rdValidOut=0, levelOut=0.
- Fill/drain sweep N=1..256:
  - Write N incrementing words (wrValidIn ignores wrReadyOut).
  - During fill: wrReadyOut=0 exactly when levelOut >= 224; almostEmptyOut=0 once levelOut >= 5.
  - Drain with rdReadyIn held high -> words 0..N-1 in order, one per cycle.
- Overflow: write 257 words with no reads -> levelOut=256, overflowOut=1, drain yields exactly the first 256 words (0..255).
- Full concurrency: at levelOut=256, push 0xDEADBEEF and pop in the same cycle -> levelOut=256, overflowOut=0, 0xDEADBEEF emerges last.
- Flush mid-stream: at levelOut=100, assert flushIn with wrValidIn=1 -> next cycle levelOut=0, rdValidOut=0, overflowOut=0. Then push 0x000000A5 -> rdValidOut=1 with 0x000000A5 two edges later.
